// File: rtl/matmul_sequencer.sv
// Control FSM sequencing one matmul on the systolic array and writing its overflow flags.
// Optional FLAGS_STICKY_EN: the flag accumulator persists across operations until clr_flags_i.
module matmul_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  parameter int DIM_W      = $clog2(MAX_DIM) + 1,
  parameter int STEP_W     = $clog2(3 * MAX_DIM) + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [DIM_W-1:0]             n_dim_i,
  input  logic [DIM_W-1:0]             k_dim_i,
  input  logic [DIM_W-1:0]             m_dim_i,
  input  logic                         clr_flags_i,
  input  logic [MAX_DIM*MAX_DIM-1:0]   ovf_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic                         array_clr_o,
  output logic                         array_en_o,
  output logic [STEP_W-1:0]            step_o,
  output logic                         flags_we_o,
  output logic [BUS_WIDTH-1:0]         flags_data_o
);

  localparam int NCELL = MAX_DIM * MAX_DIM;
  localparam logic [DIM_W-1:0] MAX_D = DIM_W'(MAX_DIM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_FLAGS,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [DIM_W-1:0]     n_q, n_d, k_q, k_d, m_q, m_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [STEP_W-1:0]    last_step;
  logic [NCELL-1:0]     acc_q, acc_d;
  logic [NCELL-1:0]     mask;
  logic [BUS_WIDTH-1:0] flags_q, flags_d;
  logic                 err_q, err_d;
  logic                 dims_ok;

  assign dims_ok = (n_dim_i != '0) && (n_dim_i <= MAX_D) &&
                   (k_dim_i != '0) && (k_dim_i <= MAX_D) &&
                   (m_dim_i != '0) && (m_dim_i <= MAX_D);

  // L-1 = n+k+m-3: the final feed step index.
  assign last_step = STEP_W'(n_q) + STEP_W'(k_q) + STEP_W'(m_q) - STEP_W'(3);

  always_comb begin
    mask = '0;
    for (int unsigned r = 0; r < MAX_DIM; r++) begin
      for (int unsigned c = 0; c < MAX_DIM; c++) begin
        mask[r*MAX_DIM+c] = (DIM_W'(r) < n_q) && (DIM_W'(c) < m_q);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    k_d         = k_q;
    m_d         = m_q;
    step_d      = step_q;
    acc_d       = acc_q;
    flags_d     = flags_q;
    err_d       = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    array_clr_o = 1'b0;
    array_en_o  = 1'b0;
    flags_we_o  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          n_d = n_dim_i;
          k_d = k_dim_i;
          m_d = m_dim_i;
          if (dims_ok) state_d = S_CLEAR;
          else         err_d   = 1'b1;
        end
      end
      S_CLEAR: begin
        busy_o      = 1'b1;
        array_clr_o = 1'b1;
        step_d      = '0;
`ifndef FLAGS_STICKY_EN
        acc_d       = '0;
`endif
        state_d     = S_FEED;
      end
      S_FEED: begin
        busy_o     = 1'b1;
        array_en_o = 1'b1;
        acc_d      = acc_q | (ovf_i & mask);
        if (step_q == last_step) begin
          step_d  = '0;
          state_d = S_DRAIN;
        end else begin
          step_d  = step_q + STEP_W'(1);
        end
      end
      S_DRAIN: begin
        busy_o  = 1'b1;
        acc_d   = acc_q | (ovf_i & mask);
        state_d = S_FLAGS;
      end
      S_FLAGS: begin
        busy_o     = 1'b1;
        flags_we_o = 1'b1;
        state_d    = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef FLAGS_STICKY_EN
    // Clear takes priority over any accumulation in the same cycle.
    if (clr_flags_i) acc_d = '0;
`endif

    // Snapshot includes the final drain sample, so FLAGS presents a stable value.
    if (state_q == S_DRAIN) flags_d = BUS_WIDTH'(acc_d);
  end

`ifndef FLAGS_STICKY_EN
  logic unused_clr_flags;
  assign unused_clr_flags = clr_flags_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      k_q     <= '0;
      m_q     <= '0;
      step_q  <= '0;
      acc_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      m_q     <= m_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign step_o       = step_q;
  assign err_o        = err_q;
  assign flags_data_o = flags_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: per-cycle comparison against a schedule-based
// model plus directed scenarios with hand-computed expectations.
module tb_matmul_sequencer;

  localparam int MAXD   = 2;
  localparam int DIM_W  = 2;
  localparam int STEP_W = 4;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic [DIM_W-1:0]  n_dim_i = '0, k_dim_i = '0, m_dim_i = '0;
  logic              clr_flags_i = 1'b0;
  logic [3:0]        ovf_i = '0;
  logic              busy_o, done_o, err_o, array_clr_o, array_en_o, flags_we_o;
  logic [STEP_W-1:0] step_o;
  logic [63:0]       flags_data_o;

  matmul_sequencer #(
    .DATA_WIDTH(32),
    .BUS_WIDTH (64)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .n_dim_i     (n_dim_i),
    .k_dim_i     (k_dim_i),
    .m_dim_i     (m_dim_i),
    .clr_flags_i (clr_flags_i),
    .ovf_i       (ovf_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .array_clr_o (array_clr_o),
    .array_en_o  (array_en_o),
    .step_o      (step_o),
    .flags_we_o  (flags_we_o),
    .flags_data_o(flags_data_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  function automatic logic [3:0] cell_mask(input int n, input int m);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < MAXD; i++)
      for (int j = 0; j < MAXD; j++)
        if (i < n && j < m) r[i*MAXD+j] = 1'b1;
    return r;
  endfunction

  // Model: an accepted op at edge c0 occupies cycles c0+1..c0+L+4 on a fixed schedule.
  int         ecnt = 0;
  bit         m_op = 1'b0;
  int         m_c0 = 0, m_L = 0, m_n = 0, m_m = 0;
  int         m_err_cyc = -1;
  logic [3:0] m_acc = '0;
  logic [3:0] m_flags = '0;

  always @(posedge clk or posedge rst_i) begin : model
    int         e;
    bit         idle;
    logic [3:0] acc_n;
    e = ecnt;
    acc_n = m_acc;
    if (rst_i) begin
      m_op      <= 1'b0;
      m_acc     <= '0;
      m_flags   <= '0;
      m_err_cyc <= -1;
    end else begin
      idle = !m_op || (e >= m_c0 + m_L + 5);
      if (m_op && e >= m_c0 + 2 && e <= m_c0 + m_L + 2)
        acc_n = acc_n | (ovf_i & cell_mask(m_n, m_m));
`ifdef FLAGS_STICKY_EN
      if (clr_flags_i) acc_n = '0;
`else
      if (m_op && e == m_c0 + 1) acc_n = '0;
`endif
      m_acc <= acc_n;
      if (m_op && e == m_c0 + m_L + 2) m_flags <= acc_n;
      if (idle && start_i) begin
        if (n_dim_i == 0 || n_dim_i > MAXD || k_dim_i == 0 || k_dim_i > MAXD ||
            m_dim_i == 0 || m_dim_i > MAXD) begin
          m_err_cyc <= e + 1;
        end else begin
          m_op <= 1'b1;
          m_c0 <= e;
          m_L  <= int'(n_dim_i) + int'(k_dim_i) + int'(m_dim_i) - 2;
          m_n  <= int'(n_dim_i);
          m_m  <= int'(m_dim_i);
        end
      end
    end
    ecnt <= ecnt + 1;
  end

  int we_cnt = 0, done_cnt = 0, err_cnt = 0, clr_cnt = 0, busy_cnt = 0;
  int last_we_cyc = -1, last_done_cyc = -1, last_clr_cyc = -1;
  logic [63:0] last_we_data = '0;

  always @(negedge clk) begin : cmp
    int c;
    bit e_busy, e_clr, e_en, e_we, e_done, e_err;
    logic [3:0] e_step;
    c = ecnt;
    e_busy = m_op && c >= m_c0 + 1 && c <= m_c0 + m_L + 3;
    e_clr  = m_op && c == m_c0 + 1;
    e_en   = m_op && c >= m_c0 + 2 && c <= m_c0 + m_L + 1;
    e_step = e_en ? 4'(c - m_c0 - 2) : 4'd0;
    e_we   = m_op && c == m_c0 + m_L + 3;
    e_done = m_op && c == m_c0 + m_L + 4;
    e_err  = (c == m_err_cyc);
    check("busy",  64'(busy_o),      64'(e_busy));
    check("clr",   64'(array_clr_o), 64'(e_clr));
    check("en",    64'(array_en_o),  64'(e_en));
    check("step",  64'(step_o),      64'(e_step));
    check("we",    64'(flags_we_o),  64'(e_we));
    check("done",  64'(done_o),      64'(e_done));
    check("err",   64'(err_o),       64'(e_err));
    check("flags", flags_data_o,     64'(m_flags));
    if (flags_we_o) begin we_cnt++; last_we_cyc = c; last_we_data = flags_data_o; end
    if (done_o) begin done_cnt++; last_done_cyc = c; end
    if (err_o) err_cnt++;
    if (array_clr_o) begin clr_cnt++; last_clr_cyc = c; end
    if (busy_o) busy_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input int n, input int k, input int m, output int e);
    start_i = 1'b1;
    n_dim_i = DIM_W'(n);
    k_dim_i = DIM_W'(k);
    m_dim_i = DIM_W'(m);
    tick();
    e = ecnt - 1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (done_o) ok = 1'b1;
    end
    check(name, 64'(ok), 64'd1);
  endtask

  initial begin : stim
    int e, e0, w0, d0, c0, b0;
    bit hit;
    repeat (2) tick();
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_flags", flags_data_o, 64'd0);
    rst_i = 1'b0;
    repeat (2) tick();

    // 2x2x2, no overflow: L=4
    ovf_i = 4'h0;
    do_start(2, 2, 2, e);
    wait_done("t1_timeout");
    check("t1_clr_lat",  64'(last_clr_cyc - e),  64'd1);
    check("t1_we_lat",   64'(last_we_cyc - e),   64'd7);
    check("t1_done_lat", 64'(last_done_cyc - e), 64'd8);
    check("t1_flags",    last_we_data,           64'h0);
    tick();

    // 1x2x2, every cell overflowing: row 1 masked, L=3
    ovf_i = 4'hF;
    do_start(1, 2, 2, e);
    wait_done("t2_timeout");
    check("t2_done_lat", 64'(last_done_cyc - e), 64'd7);
    check("t2_flags",    last_we_data,           64'h3);
    ovf_i = 4'h0;
    tick();

    // rejected starts
    e0 = err_cnt; c0 = clr_cnt; b0 = busy_cnt;
    do_start(2, 0, 2, e);
    repeat (2) tick();
    do_start(2, 2, 3, e);
    repeat (3) tick();
    check("t3_errs", 64'(err_cnt - e0),  64'd2);
    check("t3_clrs", 64'(clr_cnt - c0),  64'd0);
    check("t3_busy", 64'(busy_cnt - b0), 64'd0);

    // start held high through a 1x1x1 run
    start_i = 1'b1; n_dim_i = 2'd1; k_dim_i = 2'd1; m_dim_i = 2'd1;
    tick();
    e = ecnt - 1;
    wait_done("t4_timeout");
    check("t4_done_lat", 64'(last_done_cyc - e), 64'd5);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (array_clr_o) hit = 1'b1;
    end
    check("t4_restart_clr", 64'(last_clr_cyc - e), 64'd7);
    start_i = 1'b0;
    wait_done("t4b_timeout");
    tick();

    // reset mid-FEED at step 2
    do_start(2, 2, 2, e);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (array_en_o && step_o == 4'd2) hit = 1'b1;
    end
    check("t5_reach_step2", 64'(hit), 64'd1);
    w0 = we_cnt; d0 = done_cnt;
    rst_i = 1'b1;
    #1;
    check("t5_busy",  64'(busy_o),     64'd0);
    check("t5_en",    64'(array_en_o), 64'd0);
    check("t5_step",  64'(step_o),     64'd0);
    check("t5_flags", flags_data_o,    64'd0);
    repeat (2) tick();
    rst_i = 1'b0;
    repeat (12) tick();
    check("t5_no_we",   64'(we_cnt - w0),   64'd0);
    check("t5_no_done", 64'(done_cnt - d0), 64'd0);

`ifdef FLAGS_STICKY_EN
    clr_flags_i = 1'b1;
    tick();
    clr_flags_i = 1'b0;
    ovf_i = 4'b0001;
    do_start(2, 2, 2, e);
    wait_done("t6a_timeout");
    check("t6_run1", last_we_data, 64'h1);
    ovf_i = 4'b1000;
    tick();
    do_start(2, 2, 2, e);
    wait_done("t6b_timeout");
    check("t6_run2", last_we_data, 64'h9);
    ovf_i = 4'h0;
    tick();
    clr_flags_i = 1'b1;
    tick();
    clr_flags_i = 1'b0;
    do_start(2, 2, 2, e);
    wait_done("t6c_timeout");
    check("t6_run3", last_we_data, 64'h0);
    tick();
`endif

    // randomized traffic, including invalid dims and starts while busy
    for (int i = 0; i < 800; i++) begin
      ovf_i       = 4'($urandom);
      clr_flags_i = ($urandom % 8) == 0;
      start_i     = ($urandom % 4) == 0;
      n_dim_i     = 2'($urandom);
      k_dim_i     = 2'($urandom);
      m_dim_i     = 2'($urandom);
      tick();
    end
    start_i = 1'b0;
    clr_flags_i = 1'b0;
    repeat (15) tick();
    check("rand_ops_seen", 64'(done_cnt > 10), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
